// File: rtl/pow2_scaler_pipe_if.sv
// Handshake bundle for the power-of-two scaler. The block under test uses the
// slave view. The surrounding environment (producer and consumer) uses the
// master view.
interface pow2_scaler_pipe_if #(
   parameter int WIDTH   = 32,
   parameter int SHIFT_W = 8
);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHIFT_W-1:0] in_power;

   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_ovf;

   // Producer/consumer side: offers operands and accepts results.
   modport master (
      output in_valid,
      output in_data,
      output in_power,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ovf
   );

   // Scaler side: accepts operands and offers results.
   modport slave (
      input  in_valid,
      input  in_data,
      input  in_power,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ovf
   );

endinterface

// File: rtl/pow2_scaler_pipe.sv
// Two-stage pipelined power-of-two scaler for neuron weight/activation paths.
// It computes DATA * 2^POWER, where POWER is a signed shift amount. A positive
// POWER shifts left and can saturate and flag overflow. A negative POWER shifts
// right and can round half-up. The input and output use valid/ready handshakes.
// Stage 1 registers the operand and splits POWER into a direction and a
// magnitude. Stage 2 is the output register: it holds the shifted, rounded and
// saturated result.
module pow2_scaler_pipe #(
   parameter int WIDTH    = 32,
   parameter int SHIFT_W  = 8,
   parameter bit SIGNED   = 1'b1,
   parameter bit ROUND    = 1'b1,
   parameter bit SATURATE = 1'b1
) (
   input logic              clk,
   input logic              rst,
   pow2_scaler_pipe_if.slave bus
);

   localparam logic [SHIFT_W:0] MAG_ONE    = {{SHIFT_W{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ROUND_MASK = {{(WIDTH-1){1'b0}}, ROUND};
   localparam logic [WIDTH-1:0] POS_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

   // Flow control
   logic advance;

   // Stage 1 registers
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_data;
   logic               s1_left;
   logic [SHIFT_W:0]   s1_mag;

   // Incoming shift decode
   logic [SHIFT_W:0]   power_ext;
   logic [SHIFT_W:0]   in_mag;

   // Stage 2 (output) registers
   logic               out_valid_q;
   logic [WIDTH-1:0]   out_data_q;
   logic               out_ovf_q;

   // Datapath between the two stages
   logic [SHIFT_W:0]   mag_m1;
   logic [WIDTH-1:0]   shl;
   logic [WIDTH-1:0]   shl_back;
   logic [WIDTH-1:0]   shr;
   logic [WIDTH-1:0]   rnd_src;
   logic [WIDTH-1:0]   sat_val;
   logic [WIDTH-1:0]   left_res;
   logic [WIDTH-1:0]   right_res;
   logic [WIDTH-1:0]   next_data;
   logic               ovf_left;
   logic               next_ovf;

   // The output register moves when it is empty or is being drained.
   // Stage 1 follows the output register. Stage 1 can also accept whenever it
   // is empty, so a bubble never blocks a new operand.
   assign advance      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid || advance;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;

   // Sign-extend POWER by one bit. The most negative POWER then still has a
   // magnitude that can be represented, for example -128 gives 128.
   assign power_ext = {bus.in_power[SHIFT_W-1], bus.in_power};
   assign in_mag    = power_ext[SHIFT_W] ? (~power_ext + MAG_ONE) : power_ext;

   // Stage 1 holds the operand and the decoded direction/magnitude until the
   // output register can take the item.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_left  <= 1'b1;
         s1_mag   <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_data <= bus.in_data;
            s1_left <= !power_ext[SHIFT_W];
            s1_mag  <= in_mag;
         end
      end
   end

   // Shift, round and saturate.
   // Left-shift overflow is detected by shifting the result back. The shift
   // was lossless exactly when the shifted-back value equals the operand.
   // The rounding bit is the last bit shifted out. It is found by shifting
   // one position less than the magnitude, so a huge magnitude gives the
   // sign fill automatically.
   always_comb begin
      mag_m1 = s1_mag - MAG_ONE;
      shl    = s1_data << s1_mag;
      if (SIGNED) begin
         shl_back = $signed(shl) >>> s1_mag;
         shr      = $signed(s1_data) >>> s1_mag;
         rnd_src  = $signed(s1_data) >>> mag_m1;
         sat_val  = s1_data[WIDTH-1] ? NEG_MIN : POS_MAX;
      end else begin
         shl_back = shl >> s1_mag;
         shr      = s1_data >> s1_mag;
         rnd_src  = s1_data >> mag_m1;
         sat_val  = ALL_ONES;
      end
      ovf_left  = (shl_back != s1_data);
      left_res  = (ovf_left && SATURATE) ? sat_val : shl;
      right_res = shr + (rnd_src & ROUND_MASK);
      next_data = s1_left ? left_res : right_res;
      next_ovf  = s1_left && ovf_left;
   end

   // The output register loads only when it is free or being consumed.
   // A stalled result therefore stays stable until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else if (advance) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_data_q <= next_data;
            out_ovf_q  <= next_ovf;
         end
      end
   end

endmodule
